// File: rtl/chromosome_mutator_pkg.sv
// Shared types and constants for the chromosome mutation stage.
// State encoding and the clog2 helper used to size index and flip counters.
package chromosome_mutator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/chromosome_mutator_mutation_gate.sv
// Flip decision for one chromosome bit: strobe when the random word is below the rate.
module mutation_gate #(
   parameter int RandWidth = 8
) (
   input  logic [RandWidth-1:0] rand_word,
   input  logic [RandWidth-1:0] rate,
   output logic                 flip
);

   // Unsigned compare: rate 0 never flips, all-ones flips on every word but all-ones.
   assign flip = (rand_word < rate);

endmodule

// File: rtl/chromosome_mutator.sv
// Bit-flip mutation stage: consumes one random word per bit, LSB first.
// Optional flip counter output enabled by defining CHROMOSOME_MUTATOR_FLIP_COUNT_EN.
module chromosome_mutator
   import chromosome_mutator_pkg::*;
#(
   parameter int Width     = 8,
   parameter int RandWidth = 8
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
   ,
   localparam int CountWidth = clog2(Width + 1)
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [Width-1:0]      in_chromosome,
   input  logic [RandWidth-1:0]  rate,
   input  logic [RandWidth-1:0]  rand_word,
   output logic                  rand_ce,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [Width-1:0]      out_chromosome
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
   ,
   output logic [CountWidth-1:0] flip_count
`endif
);

   localparam int IndexWidth = clog2(Width);
   localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(Width - 1);

   state_t                state;
   logic [Width-1:0]      work;
   logic [RandWidth-1:0]  rate_q;
   logic [IndexWidth-1:0] index;
   logic                  flip;

   mutation_gate #(
      .RandWidth (RandWidth)
   ) u_gate (
      .rand_word (rand_word),
      .rate      (rate_q),
      .flip      (flip)
   );

   // Generator advances only while mutating; async reset of state drops it immediately.
   assign rand_ce        = (state == MUTATE);
   assign out_chromosome = work;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         work      <= '0;
         rate_q    <= '0;
         index     <= '0;
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
         flip_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work     <= in_chromosome;
                  rate_q   <= rate;
                  index    <= '0;
                  in_ready <= 1'b0;
                  state    <= MUTATE;
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
                  flip_count <= '0;
`endif
               end
            end

            MUTATE: begin
               if (flip) begin
                  work[index] <= ~work[index];
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
                  flip_count <= flip_count + CountWidth'(1);
`endif
               end
               // Index stops at the last bit instead of wrapping.
               if (index == LastIndex) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  index <= index + IndexWidth'(1);
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chromosome_mutator.sv
// Directed self-checking bench for chromosome_mutator (Width=8, RandWidth=8).
module tb_chromosome_mutator;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_chromosome;
   logic [7:0] rate;
   logic [7:0] rand_word;
   logic       rand_ce;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_chromosome;
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
   logic [3:0] flip_count;
`endif

   int n_checks;
   int n_fail;

   chromosome_mutator #(
      .Width     (8),
      .RandWidth (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_chromosome  (in_chromosome),
      .rate           (rate),
      .rand_word      (rand_word),
      .rand_ce        (rand_ce),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_chromosome (out_chromosome)
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
      ,
      .flip_count     (flip_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one chromosome, feed eight words LSB first, check output timing and value.
   task automatic run_chrom(input string name, input logic [7:0] din, input logic [7:0] r,
                            input logic [63:0] words, input logic [7:0] exp,
                            input int exp_flips, input bit release_out);
      in_valid      = 1'b1;
      in_chromosome = din;
      rate          = r;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_accept_ready: got %b expected 1", name, in_ready);
      end
      step();
      in_valid      = 1'b0;
      in_chromosome = ~din;
      rate          = ~r;
      for (int i = 0; i < 8; i++) begin
         rand_word = words[i*8 +: 8];
         n_checks++;
         if (rand_ce !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_mutate_cycle%0d: got ce=%b ov=%b ir=%b expected ce=1 ov=0 ir=0",
                     name, i, rand_ce, out_valid, in_ready);
         end
         step();
      end
      rand_word = 8'h00;
      n_checks++;
      if (out_valid !== 1'b1 || rand_ce !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_flags: got ov=%b ce=%b ir=%b expected ov=1 ce=0 ir=0",
                  name, out_valid, rand_ce, in_ready);
      end
      n_checks++;
      if (out_chromosome !== exp) begin
         n_fail++;
         $display("FAIL %s_result: got %h expected %h", name, out_chromosome, exp);
      end
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
      n_checks++;
      if (flip_count !== 4'(exp_flips)) begin
         n_fail++;
         $display("FAIL %s_flip_count: got %0d expected %0d", name, flip_count, exp_flips);
      end
`else
      if (exp_flips < 0) $display("negative flip expectation in %s", name);
`endif
      if (release_out) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: got ir=%b ov=%b expected ir=1 ov=0", name, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rand_ce !== 1'b0 || out_chromosome !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_values: got ir=%b ov=%b ce=%b out=%h expected ir=1 ov=0 ce=0 out=00",
                  in_ready, out_valid, rand_ce, out_chromosome);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_no_mutation();
      run_chrom("no_mut", 8'hA5, 8'h00, 64'h00FF_7F80_0112_4433, 8'hA5, 0, 1'b1);
   endtask

   task automatic test_alternating();
      // Word order is LSB first: words[7:0] goes with bit 0.
      run_chrom("alternate", 8'h00, 8'h80, 64'hFF00_FF00_FF00_FF00, 8'h55, 4, 1'b1);
   endtask

   task automatic test_backpressure();
      // Rate all-ones flips every bit except where the word is all-ones (bit 3).
      run_chrom("backpressure", 8'h0F, 8'hFF, 64'h0000_0000_FF00_0000, 8'hF8, 7, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_chromosome !== 8'hF8 || in_ready !== 1'b0 || rand_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold%0d: got ov=%b out=%h ir=%b ce=%b expected ov=1 out=f8 ir=0 ce=0",
                     i, out_valid, out_chromosome, in_ready, rand_ce);
         end
`ifdef CHROMOSOME_MUTATOR_FLIP_COUNT_EN
         n_checks++;
         if (flip_count !== 4'd7) begin
            n_fail++;
            $display("FAIL backpressure_count%0d: got %0d expected 7", i, flip_count);
         end
`endif
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_release: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      in_valid      = 1'b1;
      in_chromosome = 8'hFF;
      rate          = 8'hFF;
      rand_word     = 8'h00;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      n_checks++;
      if (rand_ce !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_precheck: got ce=%b expected 1", rand_ce);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (rand_ce !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_chromosome !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_async: got ce=%b ir=%b ov=%b out=%h expected ce=0 ir=1 ov=0 out=00",
                  rand_ce, in_ready, out_valid, out_chromosome);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++;
      if (in_ready !== 1'b1 || rand_ce !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: got ir=%b ce=%b expected ir=1 ce=0", in_ready, rand_ce);
      end
      // Flips on bits 0,2,4,7 (words 10,10,30,3F below 40): C3 ^ 95 = 56.
      run_chrom("after_reset", 8'hC3, 8'h40, 64'h3FFF_9030_5010_5010, 8'h56, 4, 1'b1);
   endtask

   task automatic test_back_to_back();
      int ready_cyc[$];
      logic [7:0] outs[$];
      in_valid      = 1'b1;
      out_ready     = 1'b1;
      in_chromosome = 8'h3C;
      rate          = 8'hFF;
      rand_word     = 8'h00;
      for (int cyc = 0; cyc < 30 && outs.size() < 2; cyc++) begin
         if (in_ready && out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_exclusive: got ir=1 ov=1 at cycle %0d expected not both", cyc);
         end
         if (in_ready) ready_cyc.push_back(cyc);
         if (out_valid) outs.push_back(out_chromosome);
         if (ready_cyc.size() == 1 && cyc == ready_cyc[0] + 1) begin
            in_chromosome = 8'h5A;
            rate          = 8'h00;
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (ready_cyc.size() < 2) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d accepts expected 2", ready_cyc.size());
      end else if (ready_cyc[1] - ready_cyc[0] !== 10) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d cycles expected 10", ready_cyc[1] - ready_cyc[0]);
      end
      n_checks++;
      if (outs.size() < 2) begin
         n_fail++;
         $display("FAIL b2b_outputs: got %0d outputs expected 2", outs.size());
      end else if (outs[0] !== 8'hC3 || outs[1] !== 8'h5A) begin
         n_fail++;
         $display("FAIL b2b_values: got %h,%h expected c3,5a", outs[0], outs[1]);
      end
      step();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_final_idle: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_chromosome = 8'h00;
      rate          = 8'h00;
      rand_word     = 8'h00;
      out_ready     = 1'b0;
      test_reset();
      test_no_mutation();
      test_alternating();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
